// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART serializer.
// Bus side pushes at clock rate; drain side launches one byte per tx_ready.
module uart_tx_fifo #(
  parameter  int DEPTH      = 16,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [7:0]            wr_data,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  input  logic                  clr_overflow,
  output logic                  tx_start,
  output logic [7:0]            tx_byte,
  input  logic                  tx_ready
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    BUSY   = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = 1;
  localparam logic [ADDR_WIDTH:0]   CNT_FULL = DEPTH;
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = 1;

  logic [7:0]            mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count_nxt;
  state_t                state;
  state_t                state_nxt;
  logic                  push;
  logic                  drop;
  logic                  pop;
  logic                  tx_start_nxt;

  // full is the registered flag, so a push racing a pop while full is dropped
  assign push = wr_en && !full;
  assign drop = wr_en && full;

  // drain sequencer: launch only from IDLE, never combinationally off tx_ready
  always_comb begin
    state_nxt    = state;
    pop          = 1'b0;
    tx_start_nxt = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty && tx_ready) begin
          state_nxt    = LAUNCH;
          pop          = 1'b1;
          tx_start_nxt = 1'b1;
        end
      end
      LAUNCH: begin
        state_nxt = BUSY;
      end
      BUSY: begin
        if (tx_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // occupancy after this edge's push/pop
  always_comb begin
    count_nxt = count;
    unique case ({push, pop})
      2'b10:   count_nxt = count + CNT_ONE;
      2'b01:   count_nxt = count - CNT_ONE;
      default: count_nxt = count;
    endcase
  end

  // storage array; contents need no reset
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // pointers and registered occupancy flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      count <= count_nxt;
      full  <= (count_nxt == CNT_FULL);
      empty <= (count_nxt == '0);
    end
  end

  // sticky drop flag; a new drop wins over a clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clr_overflow) begin
      overflow <= 1'b0;
    end
  end

  // drain state and registered launch outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      tx_start <= 1'b0;
      tx_byte  <= 8'h00;
    end else begin
      state    <= state_nxt;
      tx_start <= tx_start_nxt;
      if (pop) begin
        tx_byte <= mem[rd_ptr];
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo with a fast serializer stand-in.
// Queue model predicts every output each cycle.
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;
  localparam int BITC  = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       overflow;
  logic       clr_overflow;
  logic       tx_start;
  logic [7:0] tx_byte;
  logic       tx_ready;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  uart_tx_fifo #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .full         (full),
    .empty        (empty),
    .count        (count),
    .overflow     (overflow),
    .clr_overflow (clr_overflow),
    .tx_start     (tx_start),
    .tx_byte      (tx_byte),
    .tx_ready     (tx_ready)
  );

  // serializer stand-in: start bit, 8 data LSB first, stop bit
  logic       ready_en;
  int         ser_left;
  logic [9:0] ser_frame;
  logic [3:0] bidx;
  logic       line;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ser_left  <= 0;
      ser_frame <= '1;
    end else if (tx_start) begin
      ser_left  <= 10 * BITC;
      ser_frame <= {1'b1, tx_byte, 1'b0};
    end else if (ser_left > 0) begin
      ser_left <= ser_left - 1;
    end
  end

  assign bidx     = 4'((10 * BITC - ser_left) / BITC);
  assign line     = (ser_left == 0) ? 1'b1 : ser_frame[bidx];
  assign tx_ready = ready_en && (ser_left == 0) && !tx_start;

  // reference model: byte queue plus drain phase
  logic [7:0] q[$];
  bit         m_armed;
  bit         m_launch;
  bit         m_ov;
  logic [7:0] m_byte;
  int         accepted = 0;
  int         dropped  = 0;

  always @(posedge clk or posedge rst) begin : model
    bit was_full;
    if (rst) begin
      q.delete();
      m_armed  = 1'b1;
      m_launch = 1'b0;
      m_ov     = 1'b0;
      m_byte   = 8'h00;
    end else begin
      was_full = (q.size() == DEPTH);
      if (m_launch) begin
        m_launch = 1'b0;
      end else if (m_armed) begin
        if (tx_ready && q.size() > 0) begin
          m_byte   = q.pop_front();
          m_armed  = 1'b0;
          m_launch = 1'b1;
        end
      end else if (tx_ready) begin
        m_armed = 1'b1;
      end
      if (wr_en && !was_full) begin
        q.push_back(wr_data);
        accepted++;
      end
      if (wr_en && was_full) begin
        dropped++;
        m_ov = 1'b1;
      end else if (clr_overflow) begin
        m_ov = 1'b0;
      end
    end
  end

  // per-cycle comparison against the model
  bit         chk_en = 1'b0;
  bit         prev_ts = 1'b0;
  int         ts_count = 0;
  logic [7:0] sent[$];

  always @(negedge clk) begin
    if (chk_en) begin
      total++;
      if (count !== 5'(q.size()) || empty !== (q.size() == 0) ||
          full !== (q.size() == DEPTH) || tx_start !== m_launch ||
          tx_byte !== m_byte || overflow !== m_ov) begin
        bad++;
        $display("FAIL cycle t=%0t cnt=%0d/%0d emp=%b full=%b ts=%b/%b byte=%h/%h ov=%b/%b",
                 $time, count, q.size(), empty, full, tx_start, m_launch,
                 tx_byte, m_byte, overflow, m_ov);
      end
      if (prev_ts && tx_start) begin
        bad++;
        $display("FAIL double_start t=%0t got=11 want=10", $time);
      end
      if (tx_start === 1'b1) begin
        ts_count++;
        sent.push_back(tx_byte);
      end
      prev_ts = (tx_start === 1'b1);
    end
  end

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    bit done;
    done = 1'b0;
    for (int k = 0; k < limit; k++) begin
      if (empty && ser_left == 0 && !tx_start) begin
        done = 1'b1;
        break;
      end
      tick();
    end
    check("drain_timeout", 32'(done), 32'd1);
    repeat (3) tick();
  endtask

  initial begin : stim
    int         ts0;
    int         acc0;
    int         pushes;
    bit         ok;
    logic [9:0] cap;

    rst          = 1'b0;
    wr_en        = 1'b0;
    wr_data      = 8'h00;
    clr_overflow = 1'b0;
    ready_en     = 1'b1;
    #2 rst = 1'b1;
    chk_en = 1'b1;
    #1;
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_txbyte", 32'(tx_byte), 32'h00);
    repeat (2) tick();
    rst = 1'b0;
    tick();

    // single byte latency and framing
    push(8'hA5);
    check("t1_early_start", 32'(tx_start), 32'd0);
    check("t1_not_empty", 32'(empty), 32'd0);
    tick();
    check("t1_start", 32'(tx_start), 32'd1);
    check("t1_byte", 32'(tx_byte), 32'hA5);
    tick();
    for (int i = 0; i < 10; i++) begin
      cap[i] = line;
      repeat (BITC) tick();
    end
    check("t1_frame", 32'(cap), 32'h34A);
    check("t1_empty", 32'(empty), 32'd1);
    repeat (3) tick();

    // fill to full, then drain in order
    ready_en = 1'b0;
    for (int i = 1; i <= 16; i++) push(8'(i));
    check("t2_full", 32'(full), 32'd1);
    check("t2_count", 32'(count), 32'd16);
    check("t2_ovf", 32'(overflow), 32'd0);
    ts0 = ts_count;
    sent.delete();
    ready_en = 1'b1;
    wait_idle(16 * 30);
    check("t2_pulses", 32'(ts_count - ts0), 32'd16);
    check("t2_first", 32'(sent[0]), 32'h01);
    check("t2_last", 32'(sent[15]), 32'h10);

    // overflow set, clear, and set-wins-over-clear
    ready_en = 1'b0;
    for (int i = 0; i < 16; i++) push(8'(8'h20 + i));
    push(8'hFF);
    check("t3_ovf_set", 32'(overflow), 32'd1);
    check("t3_count", 32'(count), 32'd16);
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    check("t3_ovf_clr", 32'(overflow), 32'd0);
    clr_overflow = 1'b1;
    push(8'hFF);
    clr_overflow = 1'b0;
    check("t3_ovf_prio", 32'(overflow), 32'd1);
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    ready_en = 1'b1;
    wait_idle(16 * 30);

    // push coinciding with a launch keeps count
    ready_en = 1'b0;
    for (int i = 0; i < 5; i++) push(8'(8'h30 + i));
    check("t4_count5", 32'(count), 32'd5);
    ready_en = 1'b1;
    push(8'h35);
    check("t4_count_hold", 32'(count), 32'd5);
    check("t4_start", 32'(tx_start), 32'd1);
    check("t4_byte", 32'(tx_byte), 32'h30);
    wait_idle(8 * 30);

    // reset mid-frame discards the queue
    ready_en = 1'b0;
    for (int i = 0; i < 3; i++) push(8'(8'h40 + i));
    ready_en = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (tx_start) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check("t5_launch_seen", 32'(ok), 32'd1);
    repeat (5) tick();
    #2 rst = 1'b1;
    #1;
    check("t5_count", 32'(count), 32'd0);
    check("t5_empty", 32'(empty), 32'd1);
    check("t5_start", 32'(tx_start), 32'd0);
    check("t5_byte", 32'(tx_byte), 32'h00);
    repeat (2) tick();
    rst = 1'b0;
    ts0 = ts_count;
    ok = 1'b1;
    for (int k = 0; k < 30; k++) begin
      if (line !== 1'b1) ok = 1'b0;
      tick();
    end
    check("t5_no_start", 32'(ts_count - ts0), 32'd0);
    check("t5_line_idle", 32'(ok), 32'd1);

    // random bursts against the model
    acc0   = accepted;
    ts0    = ts_count;
    pushes = 0;
    while (pushes < 2000) begin
      int burst;
      burst = $urandom_range(1, 8);
      for (int b = 0; b < burst; b++) begin
        wr_en   = 1'b1;
        wr_data = 8'($urandom);
        tick();
        pushes++;
      end
      wr_en = 1'b0;
      repeat ($urandom_range(0, 30)) tick();
    end
    wait_idle(16 * 30);
    check("t6_delivered", 32'(ts_count - ts0), 32'(accepted - acc0));

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // hard bound on simulated time
  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

endmodule
